wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RISC-V core: a single-entry MEM→WB buffer sitting directly upstream of the register file. It accepts retiring instructions from the memory stage and waits for load data from data memory when the instruction is a load. It aligns and sign/zero-extends that load data, then drives one write per instruction into the register file, whose write port is `regWr`/`rd_addr`/`rd_data`. It also suppresses writes to x0, which the register file does not protect, and counts retired instructions.

## Interface
- No parameters (XLEN fixed at 32, 32 registers).
- `clk` in 1 — core clock. The register file writes on the falling edge; this block is rising-edge.
- `reset` in 1 — asynchronous, active-high.
- `mem_valid` in 1 — memory stage presents an instruction.
- `mem_ready` out 1 — block can accept this cycle. Combinational from state.
- `mem_regWr` in 1 — instruction writes rd.
- `mem_is_load` in 1 — rd value comes from data memory.
- `mem_funct3` in 3 — load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_rd_addr` in 5 — destination register.
- `mem_alu_result` in 32 — result for non-loads; byte address for loads.
- `dmem_rvalid` in 1 — data-memory read data valid.
- `dmem_rdata` in 32 — aligned word containing the loaded bytes.
- `wb_regWr` out 1 — register-file write enable. The register file's `memtoreg` input is tied low at top level; load writes use `wb_regWr`.
- `wb_rd_addr` out 5 — register-file write address.
- `wb_rd_data` out 32 — register-file write data.
- `wb_misalign` out 1 — one-cycle pulse on a misaligned load.
- `wb_retire_cnt` out 32 — retired-instruction counter.

## Operation
- States: EMPTY, WAIT_LOAD, WRITE. Reset state is EMPTY.
- `mem_ready` = (state == EMPTY) or (state == WRITE). An accept is `mem_valid & mem_ready`.
- On an accept, the block latches rd_addr, regWr, funct3, alu_result and is_load.
  - Non-load: next state WRITE, with the data register = `mem_alu_result`.
  - Load: next state WAIT_LOAD.
- WAIT_LOAD: holds until `dmem_rvalid`. On the `dmem_rvalid` edge, the aligned data is latched and the next state is WRITE. `mem_ready` is 0 throughout, which stalls the memory stage.
- WRITE: lasts exactly one cycle.
  - `wb_regWr` = latched regWr & (rd_addr != 0) & !misaligned.
  - `wb_retire_cnt` increments by 1 at the end of the cycle, including x0 and misaligned instructions. It wraps at 2^32 to 0.
  - Next state: if a new accept occurs, WRITE (non-load) or WAIT_LOAD (load); otherwise EMPTY.
- Load alignment uses the byte offset `off` = addr[1:0].
  - LB/LBU: select byte `off`, then sign- or zero-extend.
  - LH/LHU: select halfword at `off` (0 or 2), then extend.
  - LW: whole word.
- Misaligned loads:
  - Conditions: LH/LHU with off[0]=1, or LW with off≠0.
  - The write is suppressed and `wb_misalign` pulses during the WRITE cycle. The counter still increments.
  - Unsupported funct3 (011, 110, 111) is treated as misaligned.
- `dmem_rvalid` outside WAIT_LOAD is ignored, with no state change.
- Reset in any state, including WAIT_LOAD, forces EMPTY. A `dmem_rvalid` arriving after reset is ignored.
- Outputs when not in WRITE: `wb_regWr`=0 and `wb_misalign`=0. `wb_rd_addr` and `wb_rd_data` hold their last values.

## Timing
- All state and outputs except `mem_ready` are registered.
- Reset values: state EMPTY, `wb_regWr` 0, `wb_rd_addr` 0, `wb_rd_data` 0, `wb_misalign` 0, `wb_retire_cnt` 0. Consequently `mem_ready` is 1 out of reset.
- Non-load latency: accepted at edge T, `wb_regWr` high during cycle T→T+1. The register file commits on the falling edge inside that cycle, so a read in the next cycle sees the value.
- Load latency: `dmem_rvalid` sampled at edge R, write cycle R→R+1.
- Throughput: one non-load per cycle back-to-back, because `mem_ready` stays 1 in WRITE. Each load adds at least one WAIT_LOAD cycle.
- If `dmem_rvalid` coincides with the accept edge of the load itself, it is not consumed. The block waits for a later `dmem_rvalid` in WAIT_LOAD.

## Test plan
- Reset, then push a non-load with rd=5 and alu_result=0x0000_1234 → one cycle with `wb_regWr`=1, `wb_rd_addr`=5, `wb_rd_data`=0x1234; `wb_retire_cnt`=1.
- Three back-to-back non-loads to rd=1, 2, 3 → `mem_ready` constantly 1; three consecutive write cycles; counter=3.
- LB at addr 0x...3 with dmem_rdata=0x80FF_7F01 and rvalid 4 cycles later → `mem_ready`=0 for 4 cycles, then write data 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LH at offset 2 → 0xFFFF_80FF.
- Non-load with rd=0 and alu_result=0xDEAD_BEEF → `wb_regWr` stays 0; counter still increments.
- LW at addr 0x...2 → `wb_misalign` pulses one cycle, `wb_regWr`=0, counter increments. LH at offset 1 → same result.
- Reset asserted mid-WAIT_LOAD, then `dmem_rvalid` pulses → no write; state EMPTY, `mem_ready`=1, counter 0. Separately, a spurious `dmem_rvalid` in EMPTY → no effect.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: single-entry MEM->WB buffer that waits for load data, aligns and extends it,
// and issues one register-file write per retiring instruction. x0 writes are suppressed here.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_regWr,
  input  logic        mem_is_load,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_alu_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_regWr,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_rd_data,
  output logic        wb_misalign,
  output logic [31:0] wb_retire_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t      state, nxt_state;
  logic        ld_regwr;
  logic [4:0]  ld_rd_addr;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;

  logic        accept;
  logic        nxt_regwr;
  logic        nxt_misalign;
  logic [4:0]  nxt_rd_addr;
  logic [31:0] nxt_rd_data;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_aligned;
  logic        ld_misalign;

  // Handshake: an instruction transfers on a rising edge where mem_valid & mem_ready are both 1;
  // mem_ready depends only on state, so the memory stage may hold mem_valid without a comb loop.
  assign mem_ready = (state == EMPTY) || (state == WRITE);
  assign accept    = mem_valid & mem_ready;
  assign state_dbg = state;

  always_comb begin
    byte_sel    = 8'h00;
    half_sel    = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_aligned  = dmem_rdata;
    ld_misalign = 1'b0;
    case (ld_off)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    case (ld_funct3)
      3'b000: ld_aligned = {{24{byte_sel[7]}}, byte_sel};
      3'b100: ld_aligned = {24'h000000, byte_sel};
      3'b001: begin
        ld_aligned  = {{16{half_sel[15]}}, half_sel};
        ld_misalign = ld_off[0];
      end
      3'b101: begin
        ld_aligned  = {16'h0000, half_sel};
        ld_misalign = ld_off[0];
      end
      3'b010:  ld_misalign = (ld_off != 2'd0);
      default: ld_misalign = 1'b1;
    endcase
  end

  always_comb begin
    nxt_state    = state;
    nxt_regwr    = 1'b0;
    nxt_misalign = 1'b0;
    nxt_rd_addr  = wb_rd_addr;
    nxt_rd_data  = wb_rd_data;
    case (state)
      EMPTY, WRITE: begin
        if (accept) begin
          if (mem_is_load) begin
            nxt_state = WAIT_LOAD;
          end else begin
            nxt_state   = WRITE;
            nxt_regwr   = mem_regWr & (mem_rd_addr != 5'd0);
            nxt_rd_addr = mem_rd_addr;
            nxt_rd_data = mem_alu_result;
          end
        end else begin
          nxt_state = EMPTY;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          nxt_state    = WRITE;
          nxt_rd_addr  = ld_rd_addr;
          nxt_misalign = ld_misalign;
          nxt_regwr    = ld_regwr & (ld_rd_addr != 5'd0) & ~ld_misalign;
          if (!ld_misalign) nxt_rd_data = ld_aligned;
        end
      end
      default: nxt_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= EMPTY;
      wb_regWr      <= 1'b0;
      wb_rd_addr    <= 5'd0;
      wb_rd_data    <= 32'h0;
      wb_misalign   <= 1'b0;
      wb_retire_cnt <= 32'h0;
      ld_regwr      <= 1'b0;
      ld_rd_addr    <= 5'd0;
      ld_funct3     <= 3'b000;
      ld_off        <= 2'd0;
    end else begin
      state       <= nxt_state;
      wb_regWr    <= nxt_regwr;
      wb_rd_addr  <= nxt_rd_addr;
      wb_rd_data  <= nxt_rd_data;
      wb_misalign <= nxt_misalign;
      // Every instruction retires at the end of its WRITE cycle, even if its write was dropped.
      if (state == WRITE) wb_retire_cnt <= wb_retire_cnt + 32'd1;
      if (accept) begin
        ld_regwr   <= mem_regWr;
        ld_rd_addr <= mem_rd_addr;
        ld_funct3  <= mem_funct3;
        ld_off     <= mem_alu_result[1:0];
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: non-loads, loads with alignment/extension, x0, misalignment,
// rvalid corner cases and reset during a pending load.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic        mem_regWr = 1'b0;
  logic        mem_is_load = 1'b0;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [4:0]  mem_rd_addr = 5'd0;
  logic [31:0] mem_alu_result = 32'h0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        wb_regWr;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic        wb_misalign;
  logic [31:0] wb_retire_cnt;
  logic [1:0]  state_dbg;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = 32'h0;
  logic [31:0] exp_q[$];

  wb_stage dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_regWr(mem_regWr),
    .mem_is_load(mem_is_load), .mem_funct3(mem_funct3), .mem_rd_addr(mem_rd_addr),
    .mem_alu_result(mem_alu_result), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_regWr(wb_regWr), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .wb_misalign(wb_misalign), .wb_retire_cnt(wb_retire_cnt), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic regwr, input logic is_load, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [31:0] alu);
    mem_valid      = 1'b1;
    mem_regWr      = regwr;
    mem_is_load    = is_load;
    mem_funct3     = f3;
    mem_rd_addr    = rd;
    mem_alu_result = alu;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL reset_regwr: got %b want 0", wb_regWr); end
    n_checks++; if (wb_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", wb_rd_addr); end
    n_checks++; if (wb_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", wb_rd_data); end
    n_checks++; if (wb_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", wb_misalign); end
    n_checks++; if (wb_retire_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", wb_retire_cnt); end
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", mem_ready); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
  endtask

  task automatic test_nonload();
    drive_instr(1'b1, 1'b0, 3'b000, 5'd5, 32'h0000_1234);
    tick();
    idle();
    n_checks++; if (wb_regWr !== 1'b1) begin n_fail++; $display("FAIL nonload_regwr: got %b want 1", wb_regWr); end
    n_checks++; if (wb_rd_addr !== 5'd5) begin n_fail++; $display("FAIL nonload_rd_addr: got %0d want 5", wb_rd_addr); end
    n_checks++; if (wb_rd_data !== 32'h0000_1234) begin n_fail++; $display("FAIL nonload_rd_data: got %h want 00001234", wb_rd_data); end
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL nonload_cnt_during: got %0d want %0d", wb_retire_cnt, exp_cnt); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL nonload_regwr_after: got %b want 0", wb_regWr); end
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL nonload_cnt: got %0d want %0d", wb_retire_cnt, exp_cnt); end
    n_checks++; if (wb_rd_data !== 32'h0000_1234) begin n_fail++; $display("FAIL nonload_data_hold: got %h want 00001234", wb_rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(32'h0000_0100 + 32'(i));
      drive_instr(1'b1, 1'b0, 3'b000, 5'(i), 32'h0000_0100 + 32'(i));
      n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, mem_ready); end
      tick();
      exp_data = exp_q.pop_front();
      n_checks++; if (wb_regWr !== 1'b1) begin n_fail++; $display("FAIL b2b_regwr[%0d]: got %b want 1", i, wb_regWr); end
      n_checks++; if (wb_rd_addr !== 5'(i)) begin n_fail++; $display("FAIL b2b_rd_addr[%0d]: got %0d want %0d", i, wb_rd_addr, i); end
      n_checks++; if (wb_rd_data !== exp_data) begin n_fail++; $display("FAIL b2b_rd_data[%0d]: got %h want %h", i, wb_rd_data, exp_data); end
    end
    idle();
    tick();
    exp_cnt = exp_cnt + 3;
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", wb_retire_cnt, exp_cnt); end
    n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL b2b_regwr_end: got %b want 0", wb_regWr); end
  endtask

  task automatic test_load();
    logic [2:0]  f3_t[3]  = '{3'b000, 3'b100, 3'b001};
    logic [31:0] adr_t[3] = '{32'h0000_1003, 32'h0000_1003, 32'h0000_1002};
    logic [31:0] exp_t[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
    dmem_rdata = 32'h80FF_7F01;
    for (int k = 0; k < 3; k++) begin
      drive_instr(1'b1, 1'b1, f3_t[k], 5'd7, adr_t[k]);
      tick();
      idle();
      for (int c = 0; c < 4; c++) begin
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready[%0d.%0d]: got %b want 0", k, c, mem_ready); end
        n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL load_early_write[%0d.%0d]: got %b want 0", k, c, wb_regWr); end
        if (c == 3) dmem_rvalid = 1'b1;
        tick();
      end
      dmem_rvalid = 1'b0;
      n_checks++; if (wb_regWr !== 1'b1) begin n_fail++; $display("FAIL load_regwr[%0d]: got %b want 1", k, wb_regWr); end
      n_checks++; if (wb_rd_addr !== 5'd7) begin n_fail++; $display("FAIL load_rd_addr[%0d]: got %0d want 7", k, wb_rd_addr); end
      n_checks++; if (wb_rd_data !== exp_t[k]) begin n_fail++; $display("FAIL load_data[%0d]: got %h want %h", k, wb_rd_data, exp_t[k]); end
      n_checks++; if (wb_misalign !== 1'b0) begin n_fail++; $display("FAIL load_misalign[%0d]: got %b want 0", k, wb_misalign); end
      tick();
      exp_cnt = exp_cnt + 1;
      n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt[%0d]: got %0d want %0d", k, wb_retire_cnt, exp_cnt); end
    end
  endtask

  task automatic test_x0();
    drive_instr(1'b1, 1'b0, 3'b000, 5'd0, 32'hDEAD_BEEF);
    tick();
    idle();
    n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL x0_regwr: got %b want 0", wb_regWr); end
    n_checks++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL x0_state: got %0d want 2", state_dbg); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL x0_cnt: got %0d want %0d", wb_retire_cnt, exp_cnt); end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3_t[3]  = '{3'b010, 3'b001, 3'b011};
    logic [31:0] adr_t[3] = '{32'h0000_2002, 32'h0000_2001, 32'h0000_2000};
    dmem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 3; k++) begin
      drive_instr(1'b1, 1'b1, f3_t[k], 5'd9, adr_t[k]);
      tick();
      idle();
      dmem_rvalid = 1'b1;
      tick();
      dmem_rvalid = 1'b0;
      n_checks++; if (wb_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pulse[%0d]: got %b want 1", k, wb_misalign); end
      n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL mis_regwr[%0d]: got %b want 0", k, wb_regWr); end
      tick();
      exp_cnt = exp_cnt + 1;
      n_checks++; if (wb_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end[%0d]: got %b want 0", k, wb_misalign); end
      n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL mis_cnt[%0d]: got %0d want %0d", k, wb_retire_cnt, exp_cnt); end
    end
  endtask

  task automatic test_rvalid_on_accept();
    dmem_rdata = 32'h1234_5678;
    drive_instr(1'b1, 1'b1, 3'b010, 5'd10, 32'h0000_0004);
    dmem_rvalid = 1'b1;
    tick();
    idle();
    dmem_rvalid = 1'b0;
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL coinc_state: got %0d want 1", state_dbg); end
    tick();
    n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL coinc_no_write: got %b want 0", wb_regWr); end
    n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL coinc_ready: got %b want 0", mem_ready); end
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    n_checks++; if (wb_regWr !== 1'b1) begin n_fail++; $display("FAIL coinc_regwr: got %b want 1", wb_regWr); end
    n_checks++; if (wb_rd_data !== 32'h1234_5678) begin n_fail++; $display("FAIL coinc_data: got %h want 12345678", wb_rd_data); end
    tick();
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_load_after_write();
    drive_instr(1'b1, 1'b0, 3'b000, 5'd11, 32'h0000_0055);
    tick();
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL law_ready: got %b want 1", mem_ready); end
    drive_instr(1'b1, 1'b1, 3'b100, 5'd12, 32'h0000_3001);
    tick();
    idle();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL law_state: got %0d want 1", state_dbg); end
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL law_cnt1: got %0d want %0d", wb_retire_cnt, exp_cnt); end
    dmem_rdata  = 32'h0000_AB00;
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    n_checks++; if (wb_rd_data !== 32'h0000_00AB) begin n_fail++; $display("FAIL law_data: got %h want 000000ab", wb_rd_data); end
    n_checks++; if (wb_rd_addr !== 5'd12) begin n_fail++; $display("FAIL law_rd_addr: got %0d want 12", wb_rd_addr); end
    tick();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL law_cnt2: got %0d want %0d", wb_retire_cnt, exp_cnt); end
  endtask

  task automatic test_spurious_rvalid();
    dmem_rdata  = 32'hFFFF_FFFF;
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL spur_regwr: got %b want 0", wb_regWr); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL spur_state: got %0d want 0", state_dbg); end
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL spur_ready: got %b want 1", mem_ready); end
    n_checks++; if (wb_rd_data !== 32'h0000_00AB) begin n_fail++; $display("FAIL spur_data_hold: got %h want 000000ab", wb_rd_data); end
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL spur_cnt: got %0d want %0d", wb_retire_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    drive_instr(1'b1, 1'b1, 3'b010, 5'd13, 32'h0000_0000);
    tick();
    idle();
    tick();
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL rmw_pre_state: got %0d want 1", state_dbg); end
    #2 reset = 1'b1;
    #1;
    exp_cnt = 32'h0;
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rmw_async_state: got %0d want 0", state_dbg); end
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL rmw_async_cnt: got %0d want 0", wb_retire_cnt); end
    tick();
    reset       = 1'b0;
    dmem_rdata  = 32'h7777_7777;
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    n_checks++; if (wb_regWr !== 1'b0) begin n_fail++; $display("FAIL rmw_regwr: got %b want 0", wb_regWr); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL rmw_state: got %0d want 0", state_dbg); end
    n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_ready: got %b want 1", mem_ready); end
    n_checks++; if (wb_retire_cnt !== exp_cnt) begin n_fail++; $display("FAIL rmw_cnt: got %0d want 0", wb_retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_back_to_back();
    test_load();
    test_x0();
    test_misalign();
    test_rvalid_on_accept();
    test_load_after_write();
    test_spurious_rvalid();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
